// File: rtl/lc4_divider_seq_pkg.sv
// Shared definitions for the LC4 sequential divider: FSM states and default word width.
package lc4_divider_seq_pkg;

  localparam int unsigned LC4_WORD_W = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/lc4_div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem_i      partial remainder, low WIDTH-1 bits (top bit is always 0 before any step)
//   dvd_msb_i  next dividend bit shifted into the remainder
//   divisor_i  divisor
//   rem_o      partial remainder after this step
//   qbit_o     quotient bit produced by this step
module lc4_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-2:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign shifted = {rem_i, dvd_msb_i};

  // WIDTH+1-bit trial subtract; the extra top bit is the borrow.
  assign {borrow, diff} = {1'b0, shifted} - {1'b0, divisor_i};

  assign qbit_o = ~borrow;
  assign rem_o  = borrow ? shifted : diff;

endmodule

// File: rtl/lc4_divider_seq.sv
// Multi-cycle unsigned restoring divider for LC4 DIV/MOD.
// One quotient bit per gwe-enabled cycle; result held in DONE until consumed.
// Optional build macro: LC4_DIV_ZERO_FAST_EN -- divisor==0 skips RUN and goes straight to DONE.
// Ports:
//   clk, i_rst_n (async, active-low), gwe (0 freezes all state)
//   i_valid/o_ready  request handshake carrying i_dividend / i_divisor
//   o_valid/i_ready  result handshake carrying o_quotient / o_remainder
//   o_busy           high while iterating
module lc4_divider_seq
  import lc4_divider_seq_pkg::*;
#(
  parameter int unsigned WIDTH = LC4_WORD_W
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             gwe,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  lc4_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q[WIDTH-2:0]),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DIV_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; everything holds when gwe is low.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (gwe) begin
      unique case (state_q)
        DIV_IDLE: begin
          if (i_valid) begin
            dvd_d   = i_dividend;
            dsr_d   = i_divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV_RUN;
`ifdef LC4_DIV_ZERO_FAST_EN
            if (i_divisor == '0) begin
              dvd_d   = '0;
              state_d = DIV_DONE;
            end
`endif
          end
        end
        DIV_RUN: begin
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
            // LC4 defines x/0 and x%0 as 0.
            if (dsr_q == '0) begin
              dvd_d = '0;
              rem_d = '0;
            end
          end
        end
        DIV_DONE: begin
          if (i_ready) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == DIV_IDLE);
  assign o_busy      = (state_q == DIV_RUN);
  assign o_valid     = (state_q == DIV_DONE);
  assign o_quotient  = dvd_q;
  assign o_remainder = rem_q;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq (default build, macro undefined).
module tb_lc4_divider_seq;

  logic        clk;
  logic        i_rst_n;
  logic        gwe;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  lc4_divider_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .gwe         (gwe),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: gwe always 1; mode 1: random gwe; mode 2: gwe low for 5 edges after 4 steps.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int mode, input bit rnd_rdy);
    logic [15:0] eq, er;
    int          en, cyc;
    bit          acc, g, r, rdy, done;
    eq = (b == 16'd0) ? 16'd0 : a / b;
    er = (b == 16'd0) ? 16'd0 : a % b;
    i_valid    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    i_ready    = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      g   = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      gwe = g;
      rdy = o_ready;
      @(posedge clk);
      acc = g && rdy;
      @(negedge clk);
    end
    if (!acc) begin
      chk("accept", 32'd0, 32'd1);
      return;
    end
    // Operands are latched; scramble the request side to prove it.
    i_valid    = 1'($urandom_range(0, 1));
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
    en  = 0;
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      case (mode)
        1:       g = ($urandom_range(0, 3) != 0);
        2:       g = !(cyc >= 4 && cyc < 9);
        default: g = 1'b1;
      endcase
      if (mode != 1 && cyc == 8) chk("busy_run", 32'(o_busy), 32'd1);
      gwe = g;
      @(posedge clk);
      cyc++;
      if (g) en++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("lat_enabled", en, 16);
    if (mode != 1) chk("lat_cycles", cyc, (mode == 2) ? 21 : 16);
    chk($sformatf("quot %0d/%0d", a, b), 32'(o_quotient), 32'(eq));
    chk($sformatf("rem %0d/%0d", a, b), 32'(o_remainder), 32'(er));
    chk("done_ready_busy", {o_ready, o_busy}, 32'd0);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      r       = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      g       = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_ready = r;
      gwe     = g;
      @(posedge clk);
      @(negedge clk);
      if (r && g) done = 1'b1;
      else chk("hold", {o_valid, o_quotient, o_remainder}, {1'b1, eq, er});
    end
    chk("consumed", {o_valid, o_ready}, 32'b01);
    i_ready = 1'b0;
    gwe     = 1'b1;
  endtask

  initial begin
    logic [15:0] a, b;
    int          sel;
    i_rst_n    = 1'b0;
    gwe        = 1'b1;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_dividend = 16'd0;
    i_divisor  = 16'd0;
    #12;
    chk("reset_outs", {o_ready, o_valid, o_busy, o_quotient, o_remainder}, {3'b100, 32'd0});
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd100,   16'd7,      0, 1'b0);
    run_op(16'hFFFF,  16'h0001,   0, 1'b1);
    run_op(16'h0005,  16'h0009,   0, 1'b0);
    run_op(16'h8000,  16'h8000,   0, 1'b1);
    run_op(16'd1234,  16'd0,      0, 1'b0);
    run_op(16'd0,     16'd5,      0, 1'b0);
    run_op(16'hFFFF,  16'hFFFF,   0, 1'b0);
    run_op(16'd200,   16'd3,      2, 1'b1);

    // Async reset in the middle of RUN.
    i_valid    = 1'b1;
    i_dividend = 16'd1000;
    i_divisor  = 16'd3;
    gwe        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_reset", {o_ready, o_valid, o_busy, o_quotient, o_remainder}, {3'b100, 32'd0});
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd9, 16'd4, 0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 7);
      a   = 16'($urandom);
      b   = 16'($urandom);
      case (sel)
        0: b = 16'd0;
        1: b = 16'd1;
        2: if (b != 16'd0) a = a % b;
        3: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(a, b, 1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
